// File: rtl/register_file_sb_if.sv
// Bundle of writeback, read, issue and soft-clear signals for register_file_sb.
// The master modport drives requests; the slave modport is the register file.
interface register_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2
);
    localparam int AW = $clog2(NREGS);

    logic                  wrEn_i;
    logic [AW-1:0]         rdId_i;
    logic [XLEN-1:0]       rdData_i;
    logic [NREAD*AW-1:0]   rsId_i;
    logic [NREAD*XLEN-1:0] rsData_o;
    logic [NREAD-1:0]      rsPending_o;
    logic                  issueEn_i;
    logic [AW-1:0]         issueRd_i;
    logic                  clear_i;
    logic                  busy_o;

    modport master (
        output wrEn_i, rdId_i, rdData_i, rsId_i, issueEn_i, issueRd_i, clear_i,
        input  rsData_o, rsPending_o, busy_o
    );

    modport slave (
        input  wrEn_i, rdId_i, rdData_i, rsId_i, issueEn_i, issueRd_i, clear_i,
        output rsData_o, rsPending_o, busy_o
    );
endinterface

// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass, pending-write scoreboard
// and a one-entry-per-cycle soft-clear engine.
module register_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic               clk_i,
    input logic               reset_ni,
    register_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, CLEAR} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;

    logic idle;
    logic busy;
    logic wr_ok;
    logic iss_ok;

    assign idle   = (state_q == IDLE);
    assign busy   = (state_q == CLEAR);
    assign wr_ok  = bus.wrEn_i && !((ZERO_REG != 0) && (bus.rdId_i == '0));
    assign iss_ok = bus.issueEn_i && !((ZERO_REG != 0) && (bus.issueRd_i == '0));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            pend_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (wr_ok) regs_d[bus.rdId_i] = bus.rdData_i;
                if (bus.wrEn_i) pend_d[bus.rdId_i] = 1'b0;
                // Applied after the clear so a new producer supersedes the completing one
                if (iss_ok) pend_d[bus.issueRd_i] = 1'b1;
                if (bus.clear_i) begin
                    state_d = CLEAR;
                    ptr_d   = (ZERO_REG != 0) ? AW'(1) : '0;
                end
            end
            CLEAR: begin
                regs_d[ptr_q] = '0;
                pend_d[ptr_q] = 1'b0;
                ptr_d         = ptr_q + AW'(1);
                if (ptr_q == AW'(NREGS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   id;
        logic            hit;
        logic [XLEN-1:0] arr;

        assign id  = bus.rsId_i[k*AW +: AW];
        assign hit = (BYPASS != 0) && bus.wrEn_i && idle && (bus.rdId_i == id) &&
                     ((bus.rdId_i != '0) || (ZERO_REG == 0));
        assign arr = ((ZERO_REG != 0) && (id == '0)) ? '0 : regs_q[id];

        assign bus.rsData_o[k*XLEN +: XLEN] = hit ? bus.rdData_i : arr;
        assign bus.rsPending_o[k]           = busy ? 1'b1 : (hit ? 1'b0 : pend_q[id]);
    end

    assign bus.busy_o = busy;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed and randomized bench for register_file_sb (bypass and non-bypass builds)
// against an array-based reference model.
module tb_register_file_sb;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();
    register_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus_nb ();

    logic [AW-1:0] rs0, rs1;
    assign bus.rsId_i       = {rs1, rs0};
    assign bus_nb.rsId_i    = {rs1, rs0};
    assign bus_nb.wrEn_i    = bus.wrEn_i;
    assign bus_nb.rdId_i    = bus.rdId_i;
    assign bus_nb.rdData_i  = bus.rdData_i;
    assign bus_nb.issueEn_i = bus.issueEn_i;
    assign bus_nb.issueRd_i = bus.issueRd_i;
    assign bus_nb.clear_i   = bus.clear_i;

    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1))
        dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));
    register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0), .ZERO_REG(1))
        dut_nb (.clk_i(clk), .reset_ni(rst_n), .bus(bus_nb));

    int tests = 0;
    int fails = 0;

    // Reference model: architectural contents, pending flags, clear progress
    logic [XLEN-1:0] mreg [NREGS];
    bit              mpend [NREGS];
    bit              mbusy;
    int              mnext;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mreg[i]  = '0;
            mpend[i] = 1'b0;
        end
        mbusy = 1'b0;
        mnext = 0;
    endtask

    function automatic bit fwd(input int id, input bit byp);
        return byp && !mbusy && bus.wrEn_i && (int'(bus.rdId_i) == id) && (id != 0);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int id, input bit byp);
        if (fwd(id, byp)) return bus.rdData_i;
        if (id == 0) return '0;
        return mreg[id];
    endfunction

    function automatic logic exp_pend(input int id, input bit byp);
        if (mbusy) return 1'b1;
        if (fwd(id, byp)) return 1'b0;
        if (id == 0) return 1'b0;
        return mpend[id];
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NREAD; k++) begin
            int id;
            id = (k == 0) ? int'(rs0) : int'(rs1);
            chk($sformatf("%s_data%0d", tag, k), 64'(bus.rsData_o[k*XLEN +: XLEN]), 64'(exp_data(id, 1'b1)));
            chk($sformatf("%s_nbdata%0d", tag, k), 64'(bus_nb.rsData_o[k*XLEN +: XLEN]), 64'(exp_data(id, 1'b0)));
            chk($sformatf("%s_pend%0d", tag, k), 64'(bus.rsPending_o[k]), 64'(exp_pend(id, 1'b1)));
            chk($sformatf("%s_nbpend%0d", tag, k), 64'(bus_nb.rsPending_o[k]), 64'(exp_pend(id, 1'b0)));
        end
        chk($sformatf("%s_busy", tag), 64'(bus.busy_o), 64'(mbusy));
        chk($sformatf("%s_nbbusy", tag), 64'(bus_nb.busy_o), 64'(mbusy));
    endtask

    // Advance one clock: update the model from the inputs held before the edge
    task automatic cycle();
        if (!mbusy) begin
            if (bus.wrEn_i && bus.rdId_i != 0) mreg[bus.rdId_i] = bus.rdData_i;
            if (bus.wrEn_i) mpend[bus.rdId_i] = 1'b0;
            if (bus.issueEn_i && bus.issueRd_i != 0) mpend[bus.issueRd_i] = 1'b1;
            if (bus.clear_i) begin
                mbusy = 1'b1;
                mnext = 1;
            end
        end else begin
            mreg[mnext]  = '0;
            mpend[mnext] = 1'b0;
            mnext++;
            if (mnext == NREGS) mbusy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wrEn_i    = 1'b0;
        bus.rdId_i    = '0;
        bus.rdData_i  = '0;
        bus.issueEn_i = 1'b0;
        bus.issueRd_i = '0;
        bus.clear_i   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int w;
        idle_inputs();
        rs0 = '0;
        rs1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        rs0 = 5'd5;
        rs1 = 5'd31;
        #1;
        check_all("reset");

        // Same-cycle bypass, then array read
        bus.wrEn_i   = 1'b1;
        bus.rdId_i   = 5'd7;
        bus.rdData_i = 32'hDEADBEEF;
        rs0          = 5'd7;
        #1;
        chk("byp_direct", 64'(bus.rsData_o[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
        chk("nobyp_direct", 64'(bus_nb.rsData_o[XLEN-1:0]), 64'h0);
        check_all("byp");
        cycle();
        bus.wrEn_i = 1'b0;
        #1;
        chk("after_wr", 64'(bus.rsData_o[XLEN-1:0]), 64'h0000_0000_DEAD_BEEF);
        check_all("after_wr");

        // Index 0 ignores writes and issue
        bus.wrEn_i    = 1'b1;
        bus.rdId_i    = 5'd0;
        bus.rdData_i  = 32'h1234;
        bus.issueEn_i = 1'b1;
        bus.issueRd_i = 5'd0;
        rs0 = 5'd0;
        rs1 = 5'd0;
        #1;
        check_all("x0_same");
        cycle();
        idle_inputs();
        #1;
        chk("x0_data", 64'(bus.rsData_o), 64'h0);
        chk("x0_pend", 64'(bus.rsPending_o), 64'h0);
        check_all("x0_after");

        // Scoreboard set / set-wins / clear with bypass
        bus.issueEn_i = 1'b1;
        bus.issueRd_i = 5'd3;
        cycle();
        idle_inputs();
        rs0 = 5'd3;
        #1;
        chk("sb_set", 64'(bus.rsPending_o[0]), 64'h1);
        check_all("sb_set");
        bus.wrEn_i    = 1'b1;
        bus.rdId_i    = 5'd3;
        bus.rdData_i  = 32'h33;
        bus.issueEn_i = 1'b1;
        bus.issueRd_i = 5'd3;
        cycle();
        idle_inputs();
        #1;
        chk("sb_setwins", 64'(bus.rsPending_o[0]), 64'h1);
        bus.wrEn_i   = 1'b1;
        bus.rdId_i   = 5'd3;
        bus.rdData_i = 32'h3333;
        #1;
        chk("sb_byp_pend", 64'(bus.rsPending_o[0]), 64'h0);
        chk("sb_nobyp_pend", 64'(bus_nb.rsPending_o[0]), 64'h1);
        check_all("sb_clr");
        cycle();
        idle_inputs();
        #1;
        chk("sb_cleared", 64'(bus.rsPending_o[0]), 64'h0);
        check_all("sb_after");

        // Randomized traffic including occasional soft clears
        for (int n = 0; n < 300; n++) begin
            bus.wrEn_i    = 1'($urandom_range(0, 1));
            bus.rdId_i    = AW'($urandom);
            bus.rdData_i  = $urandom;
            bus.issueEn_i = 1'($urandom_range(0, 1));
            bus.issueRd_i = AW'($urandom);
            bus.clear_i   = ($urandom_range(0, 59) == 0);
            rs0 = ($urandom_range(0, 3) == 0) ? bus.rdId_i : AW'($urandom);
            rs1 = AW'($urandom);
            #1;
            check_all("rnd");
            cycle();
        end
        idle_inputs();
        w = 0;
        while (mbusy && w < 40) begin
            cycle();
            w++;
        end
        #1;
        chk("rnd_idle", 64'(bus.busy_o), 64'h0);

        // Soft clear over a full array with one pending register
        for (int i = 1; i < NREGS; i++) begin
            bus.wrEn_i   = 1'b1;
            bus.rdId_i   = AW'(i);
            bus.rdData_i = 32'(i);
            if (i == NREGS - 1) begin
                bus.issueEn_i = 1'b1;
                bus.issueRd_i = 5'd9;
            end
            cycle();
        end
        idle_inputs();
        rs0 = 5'd9;
        rs1 = 5'd4;
        #1;
        chk("fill_pend9", 64'(bus.rsPending_o[0]), 64'h1);
        chk("fill_r4", 64'(bus.rsData_o[2*XLEN-1:XLEN]), 64'h4);
        bus.clear_i = 1'b1;
        cycle();
        bus.clear_i = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.busy_o) busy_cnt++;
            if (c == 5) begin
                bus.wrEn_i   = 1'b1;
                bus.rdId_i   = 5'd4;
                bus.rdData_i = 32'hFFFF;
            end else begin
                bus.wrEn_i = 1'b0;
            end
            #1;
            if (c == 0) chk("clr_forced", 64'(bus.rsPending_o), 64'h3);
            check_all($sformatf("clr%0d", c));
            cycle();
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd31);
        idle_inputs();
        for (int i = 0; i < NREGS; i++) begin
            rs0 = AW'(i);
            #1;
            chk($sformatf("postclr_r%0d", i), 64'(bus.rsData_o[XLEN-1:0]), 64'h0);
            chk($sformatf("postclr_p%0d", i), 64'(bus.rsPending_o[0]), 64'h0);
        end

        // Asynchronous reset in the middle of a clear
        for (int i = 1; i <= 12; i++) begin
            bus.wrEn_i   = 1'b1;
            bus.rdId_i   = AW'(i);
            bus.rdData_i = 32'h100 + 32'(i);
            cycle();
        end
        idle_inputs();
        rs0 = 5'd12;
        rs1 = 5'd11;
        bus.clear_i = 1'b1;
        cycle();
        bus.clear_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_all($sformatf("pre_rst%0d", c));
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", 64'(bus.busy_o), 64'h0);
        chk("arst_r12", 64'(bus.rsData_o[XLEN-1:0]), 64'h0);
        chk("arst_r11", 64'(bus.rsData_o[2*XLEN-1:XLEN]), 64'h0);
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.wrEn_i   = 1'b1;
        bus.rdId_i   = 5'd2;
        bus.rdData_i = 32'hABCD_0002;
        cycle();
        idle_inputs();
        rs0 = 5'd2;
        #1;
        chk("post_rst_wr", 64'(bus.rsData_o[XLEN-1:0]), 64'h0000_0000_ABCD_0002);
        check_all("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised successor to the core's flat 32x32 register file. It adds configurable width, depth and read-port count, optional write-to-read bypass, and a per-register scoreboard of pending writes. It also has a sequential soft-clear engine that zeroes the array one entry per cycle. It sits between decode (reads, issue) and writeback (writes) in the pipeline and drives the hazard/stall logic.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of 2, >=4); AW = $clog2(NREGS) derived locally
NREAD, 2, number of independent asynchronous read ports
BYPASS, 1, 1 = same-cycle writeback data forwarded to reads; 0 = reads see array only
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
clk_i  in  1  clock, all state updates on rising edge
reset_ni  in  1  asynchronous, active-low reset
wrEn_i  in  1  writeback valid
rdId_i  in  AW  writeback destination index
rdData_i  in  XLEN  writeback data
rsId_i  in  NREAD*AW  packed read indices, port k at [k*AW +: AW]
rsData_o  out  NREAD*XLEN  packed read data, port k at [k*XLEN +: XLEN]
rsPending_o  out  NREAD  port k source has an outstanding write
issueEn_i  in  1  instruction issued that will write issueRd_i
issueRd_i  in  AW  destination index of the issuing instruction
clear_i  in  1  pulse: start soft clear of all registers
busy_o  out  1  soft clear in progress

Behaviour:
- Clock and reset: one clock (clk_i); reset_ni is asynchronous, active-low. On assertion, immediately: all registers = 0, all pending bits = 0, FSM = IDLE, pointer = 0, busy_o = 0.
- Write: at posedge, if wrEn_i and FSM = IDLE, reg[rdId_i] <= rdData_i.
  - With ZERO_REG=1, writes to index 0 are discarded.
- Read: combinational, no latency. rsData_o[k] = reg[rsId_k]; index 0 reads 0 when ZERO_REG=1.
  - Bypass: if BYPASS=1, wrEn_i, FSM = IDLE, rdId_i == rsId_k and (rdId_i != 0 or ZERO_REG=0), then rsData_o[k] = rdData_i in the same cycle.
- Scoreboard, one pending bit per register, at posedge while FSM = IDLE:
  - set pending[issueRd_i] when issueEn_i (never for index 0 with ZERO_REG=1);
  - clear pending[rdId_i] when wrEn_i.
  - Same index set and cleared in the same cycle: set wins, because the new producer supersedes the completing one.
  - Re-issue to an already-pending register leaves it pending; there is no counting.
- rsPending_o[k] = pending[rsId_k], except:
  - 0 when a same-cycle bypassing write to that index exists (BYPASS=1);
  - forced 1 on all ports while busy_o = 1.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_i. Pointer loads ZERO_REG ? 1 : 0.
  - In CLEAR, each cycle: reg[ptr] <= 0, pending[ptr] <= 0, ptr <= ptr + 1.
  - CLEAR -> IDLE in the cycle after the entry at ptr = NREGS-1 is cleared. The pointer wraps to 0 and does not reload.
  - busy_o = 1 exactly while in CLEAR: NREGS-1 cycles (ZERO_REG=1) or NREGS cycles (ZERO_REG=0).
  - In CLEAR: wrEn_i and issueEn_i are ignored (no write, no scoreboard change), clear_i is ignored, and reads return the current array contents with no bypass.
  - A clear_i coinciding with wrEn_i in IDLE: the write completes that cycle, then clearing starts the next cycle.
- Reset asserted mid-clear: the FSM aborts to IDLE and every register is 0 immediately.
- Widths: no arithmetic beyond the AW-bit pointer increment. Index compares are full AW bits.

Test Plan:
- Reset then read: deassert reset_ni, drive rsId port0=5, port1=31 -> rsData_o both 0, rsPending_o=00, busy_o=0.
- Write/bypass: wrEn=1, rdId=7, rdData=0xDEADBEEF, rsId0=7 in the same cycle -> rsData0=0xDEADBEEF combinationally (BYPASS=1). The next cycle with wrEn=0 reads 0xDEADBEEF. With BYPASS=0 the same-cycle read returns 0.
- x0 behaviour: write 0x1234 to index 0 and issueEn with issueRd=0 -> reads of index 0 return 0 and rsPending stays 0.
- Scoreboard: issue rd=3 -> next cycle rsPending0=1 for rsId0=3. A cycle with wrEn rd=3 and issueEn rd=3 together -> still pending afterwards. A following wrEn rd=3 alone -> pending clears; same-cycle rsPending0=0 via bypass.
- Soft clear: fill regs 1..31 with index values and issue rd=9, then pulse clear_i:
  - busy_o=1 for exactly 31 cycles and rsPending forced 11;
  - a wrEn to reg 4 mid-clear has no effect;
  - at the end, all registers read 0 and all pending bits are 0.
- Async reset mid-clear: pull reset_ni low off-edge at clear cycle 10 -> busy_o=0 and register reads return 0 without waiting for a clock edge. After release, FSM is IDLE and a new write to reg 2 succeeds.
